ddr_port_arbiter: RTL and testbench

//  Shares the single DDR burst interface (wr_req/rd_req/cmd_addr/bst_len/avl_be/data_in/data_out/ddr_rdy/ddr_vld)

---
 rtl/ddr_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_port_arbiter - round-robin sharing of one DDR burst port among clients
// Revision 1.0
// ---------------------------------------------------------------------------
module ddr_port_arbiter #(
  parameter int NUM_PORT = 3,
  parameter int MAX_BST  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORT-1:0]     cl_req,
  input  logic [NUM_PORT-1:0]     cl_we,
  input  logic [NUM_PORT*26-1:0]  cl_addr,
  input  logic [NUM_PORT*7-1:0]   cl_len,
  input  logic [NUM_PORT*64-1:0]  cl_be,
  input  logic [NUM_PORT*512-1:0] cl_wdata,
  output logic [NUM_PORT-1:0]     cl_gnt,
  output logic [NUM_PORT-1:0]     cl_wr_rdy,
  output logic [NUM_PORT-1:0]     cl_rd_vld,
  output logic [511:0]            cl_rdata,
  output logic                    ddr_wr_req,
  output logic                    ddr_rd_req,
  output logic [25:0]             ddr_addr,
  output logic [6:0]              ddr_bst_len,
  output logic [63:0]             ddr_be,
  output logic [511:0]            ddr_wdata,
  input  logic [511:0]            ddr_rdata,
  input  logic                    ddr_rdy,
  input  logic                    ddr_vld,
  output logic                    busy,
  output logic                    err_len,
  output logic                    err_vld
);

  localparam int                   IDXW      = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam logic [IDXW-1:0]      LAST_PORT = IDXW'(NUM_PORT - 1);
  localparam logic [6:0]           MAX_LEN   = 7'(MAX_BST);
  localparam logic [NUM_PORT-1:0]  PORT0_OH  = NUM_PORT'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

  state_t          state;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] pick_idx;
  logic            pick_vld;
  logic [25:0]     addr_q;
  logic [6:0]      len_q;
  logic [6:0]      cnt;
  logic            last_beat;
  logic [NUM_PORT-1:0] gnt_oh;

  logic [511:0] wdata_arr [NUM_PORT];
  logic [63:0]  be_arr    [NUM_PORT];
  logic [25:0]  addr_arr  [NUM_PORT];
  logic [6:0]   len_arr   [NUM_PORT];

  generate
    for (genvar p = 0; p < NUM_PORT; p++) begin : g_unpack
      assign wdata_arr[p] = cl_wdata[p*512 +: 512];
      assign be_arr[p]    = cl_be[p*64 +: 64];
      assign addr_arr[p]  = cl_addr[p*26 +: 26];
      assign len_arr[p]   = cl_len[p*7 +: 7];
    end
  endgenerate

  // First requester after the last winner, wrapping around.
  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = 0; i < NUM_PORT; i++) begin
      cand = int'(rr_ptr) + 1 + i;
      if (cand >= NUM_PORT) cand = cand - NUM_PORT;
      if (!pick_vld && cl_req[cand[IDXW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDXW-1:0];
      end
    end
  end

  assign last_beat   = (cnt == len_q - 7'd1);
  assign gnt_oh      = PORT0_OH << gnt_idx;
  assign busy        = (state != IDLE);
  assign cl_gnt      = busy ? gnt_oh : '0;
  assign cl_wr_rdy   = (state == WR_BURST && ddr_rdy) ? gnt_oh : '0;
  assign cl_rd_vld   = (state == RD_DATA && ddr_vld) ? gnt_oh : '0;
  assign cl_rdata    = ddr_rdata;
  assign ddr_wr_req  = (state == WR_BURST);
  assign ddr_rd_req  = (state == RD_CMD);
  assign ddr_addr    = addr_q;
  assign ddr_bst_len = len_q;
  assign ddr_wdata   = (state == WR_BURST) ? wdata_arr[gnt_idx] : '0;

  always_comb begin
    ddr_be = '0;
    if (state == WR_BURST)    ddr_be = be_arr[gnt_idx];
    else if (state == RD_CMD) ddr_be = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= LAST_PORT;
      addr_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      err_len <= 1'b0;
      err_vld <= 1'b0;
    end else begin
      // Read beats arriving outside the data phase are dropped.
      if (ddr_vld && state != RD_DATA) err_vld <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_idx <= pick_idx;
            rr_ptr  <= pick_idx;
            addr_q  <= addr_arr[pick_idx];
            cnt     <= '0;
            if (len_arr[pick_idx] == 7'd0) begin
              len_q   <= 7'd1;
              err_len <= 1'b1;
            end else if (len_arr[pick_idx] > MAX_LEN) begin
              len_q   <= MAX_LEN;
              err_len <= 1'b1;
            end else begin
              len_q   <= len_arr[pick_idx];
            end
            state <= cl_we[pick_idx] ? WR_BURST : RD_CMD;
          end
        end
        WR_BURST: begin
          if (ddr_rdy) begin
            if (last_beat) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + 7'd1;
            end
          end
        end
        RD_CMD: begin
          if (ddr_rdy) begin
            state <= RD_DATA;
            cnt   <= '0;
          end
        end
        RD_DATA: begin
          if (ddr_vld) begin
            if (last_beat) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ddr_port_arbiter - directed scoreboard bench for ddr_port_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ddr_port_arbiter;

  localparam int NP = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   cl_req, cl_we;
  logic [NP*26-1:0]  cl_addr;
  logic [NP*7-1:0]   cl_len;
  logic [NP*64-1:0]  cl_be;
  logic [NP*512-1:0] cl_wdata;
  logic [NP-1:0]   cl_gnt, cl_wr_rdy, cl_rd_vld;
  logic [511:0]    cl_rdata;
  logic            ddr_wr_req, ddr_rd_req;
  logic [25:0]     ddr_addr;
  logic [6:0]      ddr_bst_len;
  logic [63:0]     ddr_be;
  logic [511:0]    ddr_wdata, ddr_rdata;
  logic            ddr_rdy, ddr_vld;
  logic            busy, err_len, err_vld;

  ddr_port_arbiter #(.NUM_PORT(NP), .MAX_BST(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_len(cl_len),
    .cl_be(cl_be), .cl_wdata(cl_wdata),
    .cl_gnt(cl_gnt), .cl_wr_rdy(cl_wr_rdy), .cl_rd_vld(cl_rd_vld), .cl_rdata(cl_rdata),
    .ddr_wr_req(ddr_wr_req), .ddr_rd_req(ddr_rd_req), .ddr_addr(ddr_addr),
    .ddr_bst_len(ddr_bst_len), .ddr_be(ddr_be), .ddr_wdata(ddr_wdata),
    .ddr_rdata(ddr_rdata), .ddr_rdy(ddr_rdy), .ddr_vld(ddr_vld),
    .busy(busy), .err_len(err_len), .err_vld(err_vld)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic [511:0] data; logic [63:0] be; } beat_t;
  typedef struct { int port; logic we; logic [25:0] addr; logic [6:0] len; } gnt_t;

  beat_t wq[$];
  beat_t rq[$];
  gnt_t  gq[$];

  int checks = 0;
  int errors = 0;
  int wbeat [NP];
  int wpush [NP];
  int wr_pulse [NP];
  int rd_pulse [NP];
  int wr_req_cyc, rd_req_cyc, busy_cyc, gnt_rise;
  logic [NP-1:0] prev_gnt;

  function automatic logic [511:0] pat(int p, int k);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(p) * 32'h0001_0000 + 32'(k);
    return {16{w}};
  endfunction

  function automatic logic [63:0] bep(int p);
    logic [7:0] b;
    b = 8'h5A ^ 8'(p * 17);
    return {8{b}};
  endfunction

  function automatic logic [NP-1:0] oh(int p);
    logic [NP-1:0] one;
    one = NP'(1);
    return one << p;
  endfunction

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int p = 0; p < NP; p++) cl_wdata[p*512 +: 512] = pat(p, wbeat[p]);
  endtask

  // Sample at the falling edge, then step to just after the next rising edge.
  task automatic cyc();
    beat_t b;
    gnt_t  g;
    @(negedge clk);
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (|cl_wr_rdy) begin
        chk("wq_has_entry", 640'(wq.size() != 0), 640'(1));
        if (wq.size() != 0) begin
          b = wq.pop_front();
          chk("wr_rdy_port", 640'(cl_wr_rdy), 640'(oh(b.port)));
          chk("wdata", 640'(ddr_wdata), 640'(b.data));
          chk("wbe", 640'(ddr_be), 640'(b.be));
        end
      end
      if (|cl_rd_vld) begin
        chk("rq_has_entry", 640'(rq.size() != 0), 640'(1));
        if (rq.size() != 0) begin
          b = rq.pop_front();
          chk("rd_vld_port", 640'(cl_rd_vld), 640'(oh(b.port)));
          chk("rdata", 640'(cl_rdata), 640'(b.data));
        end
      end
      if (cl_gnt != '0 && prev_gnt == '0) begin
        gnt_rise++;
        chk("gq_has_entry", 640'(gq.size() != 0), 640'(1));
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("gnt", 640'(cl_gnt), 640'(oh(g.port)));
          chk("req_kind", 640'({ddr_wr_req, ddr_rd_req}), 640'(g.we ? 2'b10 : 2'b01));
          chk("addr", 640'(ddr_addr), 640'(g.addr));
          chk("bst_len", 640'(ddr_bst_len), 640'(g.len));
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (cl_wr_rdy[p]) begin wr_pulse[p]++; wbeat[p]++; end
        if (cl_rd_vld[p]) rd_pulse[p]++;
      end
      wr_req_cyc += int'(ddr_wr_req);
      rd_req_cyc += int'(ddr_rd_req);
      busy_cyc   += int'(busy);
      prev_gnt = cl_gnt;
    end
    @(posedge clk);
    #1;
    drive_data();
  endtask

  task automatic clr();
    for (int p = 0; p < NP; p++) begin wr_pulse[p] = 0; rd_pulse[p] = 0; end
    wr_req_cyc = 0; rd_req_cyc = 0; busy_cyc = 0; gnt_rise = 0;
  endtask

  task automatic setreq(input int p, input logic we, input logic [25:0] a, input logic [6:0] l);
    cl_req[p] = 1'b1;
    cl_we[p]  = we;
    cl_addr[p*26 +: 26] = a;
    cl_len[p*7 +: 7]    = l;
  endtask

  task automatic exp_gnt(input int p, input logic we, input logic [25:0] a, input logic [6:0] l);
    gnt_t g;
    g.port = p; g.we = we; g.addr = a; g.len = l;
    gq.push_back(g);
  endtask

  task automatic exp_wr(input int p, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = p; b.data = pat(p, wpush[p]); b.be = bep(p);
      wq.push_back(b);
      wpush[p]++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin cyc(); n++; end
    chk({tag, "_idle_timeout"}, 640'(busy), 640'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [639:0] all_outs();
    return 640'({cl_gnt, cl_wr_rdy, cl_rd_vld, ddr_wr_req, ddr_rd_req, ddr_addr,
                 ddr_bst_len, ddr_be, ddr_wdata, busy, err_len, err_vld});
  endfunction

  initial begin
    beat_t rb;
    rst_n = 1'b0;
    cl_req = '0; cl_we = '0; cl_addr = '0; cl_len = '0; cl_be = '0;
    ddr_rdata = '0; ddr_rdy = 1'b0; ddr_vld = 1'b0;
    prev_gnt = '0;
    for (int p = 0; p < NP; p++) begin
      wbeat[p] = 0; wpush[p] = 0;
      cl_be[p*64 +: 64] = bep(p);
    end
    drive_data();
    clr();

    // Reset state
    @(posedge clk); #1;
    chk("reset_outputs", all_outs(), 640'(0));
    do_reset();
    chk("post_reset_busy", 640'(busy), 640'(0));

    // T1: port0 write, len 4, ddr_rdy stalls two cycles after first beat
    clr();
    ddr_rdy = 1'b1;
    setreq(0, 1'b1, 26'h100, 7'd4);
    exp_gnt(0, 1'b1, 26'h100, 7'd4);
    exp_wr(0, 4);
    cyc();
    cl_req = '0;
    cyc();
    ddr_rdy = 1'b0;
    cyc(); cyc();
    ddr_rdy = 1'b1;
    cyc(); cyc(); cyc();
    chk("t1_busy", 640'(busy), 640'(0));
    chk("t1_gnt_dropped", 640'(cl_gnt), 640'(0));
    chk("t1_wr_req_cycles", 640'(wr_req_cyc), 640'(6));
    chk("t1_wr_pulses", 640'(wr_pulse[0]), 640'(4));

    // T2: port1 read, len 8, command stalls three cycles
    clr();
    ddr_rdy = 1'b0;
    setreq(1, 1'b0, 26'h2000, 7'd8);
    exp_gnt(1, 1'b0, 26'h2000, 7'd8);
    cyc();
    cl_req = '0;
    cyc(); cyc(); cyc();
    ddr_rdy = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin ddr_vld = 1'b0; cyc(); end
      ddr_vld = 1'b1;
      ddr_rdata = {16{32'hCAFE_0000 + 32'(i)}};
      rb.port = 1; rb.data = ddr_rdata; rb.be = '0;
      rq.push_back(rb);
      cyc();
    end
    ddr_vld = 1'b0;
    ddr_rdata = '0;
    chk("t2_rd_req_cycles", 640'(rd_req_cyc), 640'(4));
    chk("t2_rd_pulses_p1", 640'(rd_pulse[1]), 640'(8));
    chk("t2_rd_pulses_other", 640'(rd_pulse[0] + rd_pulse[2]), 640'(0));
    chk("t2_busy", 640'(busy), 640'(0));

    // T3: all ports request continuously, single-beat writes
    do_reset();
    clr();
    ddr_rdy = 1'b1;
    for (int p = 0; p < NP; p++) setreq(p, 1'b1, 26'(32'h10 * p), 7'd1);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) begin
        exp_gnt(p, 1'b1, 26'(32'h10 * p), 7'd1);
        exp_wr(p, 1);
      end
    for (int i = 0; i < 12; i++) cyc();
    cl_req = '0;
    wait_idle("t3", 4);
    chk("t3_grants", 640'(gnt_rise), 640'(6));
    chk("t3_busy_cycles", 640'(busy_cyc), 640'(6));

    // T4: port2 length 0 then length 100
    clr();
    chk("t4_err_len_before", 640'(err_len), 640'(0));
    setreq(2, 1'b1, 26'h300, 7'd0);
    exp_gnt(2, 1'b1, 26'h300, 7'd1);
    exp_wr(2, 1);
    cyc();
    cl_req = '0;
    chk("t4_err_len_zero", 640'(err_len), 640'(1));
    wait_idle("t4a", 8);
    setreq(2, 1'b1, 26'h400, 7'd100);
    exp_gnt(2, 1'b1, 26'h400, 7'd64);
    exp_wr(2, 64);
    cyc();
    cl_req = '0;
    wait_idle("t4b", 80);
    chk("t4_wr_pulses", 640'(wr_pulse[2]), 640'(65));
    chk("t4_bst_len_held", 640'(ddr_bst_len), 640'(64));
    chk("t4_err_len_sticky", 640'(err_len), 640'(1));

    // T5: reset during third beat of a 16-beat write
    clr();
    setreq(0, 1'b1, 26'h500, 7'd16);
    exp_gnt(0, 1'b1, 26'h500, 7'd16);
    exp_wr(0, 16);
    cyc();
    cl_req = '0;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", all_outs(), 640'(0));
    chk("t5_beats_taken", 640'(wr_pulse[0]), 640'(2));
    chk("t5_beats_left", 640'(wq.size()), 640'(14));
    wq.delete();
    wpush[0] = wbeat[0];
    cyc(); cyc();
    rst_n = 1'b1;
    setreq(0, 1'b1, 26'h600, 7'd1);
    setreq(2, 1'b1, 26'h700, 7'd1);
    exp_gnt(0, 1'b1, 26'h600, 7'd1);
    exp_wr(0, 1);
    cyc();
    cl_req = '0;
    wait_idle("t5", 4);

    // T6: stray ddr_vld while idle and during a write burst
    clr();
    chk("t6_err_vld_before", 640'(err_vld), 640'(0));
    ddr_vld = 1'b1;
    ddr_rdata = {16{32'hBAD0_0001}};
    cyc();
    ddr_vld = 1'b0;
    chk("t6_err_vld_idle", 640'(err_vld), 640'(1));
    setreq(1, 1'b1, 26'h800, 7'd4);
    exp_gnt(1, 1'b1, 26'h800, 7'd4);
    exp_wr(1, 4);
    cyc();
    cl_req = '0;
    cyc();
    ddr_vld = 1'b1;
    cyc();
    ddr_vld = 1'b0;
    wait_idle("t6", 10);
    chk("t6_wr_pulses", 640'(wr_pulse[1]), 640'(4));
    chk("t6_no_rd_vld", 640'(rd_pulse[0] + rd_pulse[1] + rd_pulse[2]), 640'(0));
    chk("t6_err_vld_sticky", 640'(err_vld), 640'(1));

    chk("end_wq_empty", 640'(wq.size()), 640'(0));
    chk("end_rq_empty", 640'(rq.size()), 640'(0));
    chk("end_gq_empty", 640'(gq.size()), 640'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
